// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Purpose : Shared types for the cache/RAM side of the CPU.
//           - word_t      : 32-bit data/address word
//           - ramstate_t  : status reported by the single-port RAM
//           - arb_state_t : state encoding of the memory arbiter FSM
// Ports   : none (package)
// ---------------------------------------------------------------------------
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      DGNT = 2'd1,
      IGNT = 2'd2
   } arb_state_t;

   // Width of the icache starvation counter.
   localparam int STARVE_W = 3;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Purpose : Registered arbiter between the icache and dcache and the
//           single-port RAM. One cache is granted at a time and its request
//           is steered to the RAM; RAM data and wait go back to that cache.
//           A dcache grant is held across both words of a two-word block so
//           an instruction fetch can never split a block.
// Params  : STARVE_LIMIT - consecutive dcache-won arbitrations with iREN
//                          pending before the icache is forced one grant
// Ports   : CLK       in   clock, rising edge
//           nRST      in   asynchronous active-low reset
//           iREN      in   icache read request
//           iaddr     in   icache word address
//           iwait     out  icache stall, 0 only in the completing cycle
//           iload     out  icache read data
//           dREN      in   dcache read request
//           dWEN      in   dcache write request
//           daddr     in   dcache word address, bit 2 selects block word
//           dstore    in   dcache write data
//           dwait     out  dcache stall, 0 only in the completing cycle
//           dload     out  dcache read data
//           ramREN    out  RAM read
//           ramWEN    out  RAM write
//           ramaddr   out  RAM address
//           ramstore  out  RAM write data
//           ramload   in   RAM read data
//           ramstate  in   RAM status (ramstate_t)
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate
);

   import cpu_types_pkg::*;

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   arb_state_t          state_q, state_d;
   logic                lock_q, lock_d;
   logic [STARVE_W-1:0] starve_q, starve_d;

   ramstate_t ram_state;
   logic      dreq;
   logic      ram_done;

   assign ram_state = ramstate_t'(ramstate);
   assign dreq      = dREN | dWEN;
   // ERROR is deliberately not a completion: the request stays on the bus
   // and is retried exactly like BUSY.
   assign ram_done  = (ram_state == ACCESS);

   // Next-state logic. The starve counter only moves on arbitration
   // decisions taken in ARB, so the second word of a locked block does not
   // count against the icache.
   always_comb begin
      state_d  = state_q;
      lock_d   = lock_q;
      starve_d = starve_q;
      case (state_q)
         ARB: begin
            if (dreq && iREN) begin
               if (starve_q < STARVE_MAX) begin
                  state_d  = DGNT;
                  starve_d = starve_q + STARVE_W'(1);
               end else begin
                  state_d  = IGNT;
                  starve_d = '0;
               end
            end else if (dreq) begin
               state_d  = DGNT;
               starve_d = '0;
            end else if (iREN) begin
               state_d  = IGNT;
               starve_d = '0;
            end
         end
         DGNT: begin
            if (!dreq) begin
               // dcache dropped its request (e.g. halt mid-block)
               state_d = ARB;
               lock_d  = 1'b0;
            end else if (ram_done) begin
               if (daddr[2]) begin
                  state_d = ARB;
                  lock_d  = 1'b0;
               end else begin
                  lock_d  = 1'b1;
               end
            end
         end
         IGNT: begin
            if (!iREN || ram_done) begin
               state_d = ARB;
            end
         end
         default: begin
            state_d = ARB;
            lock_d  = 1'b0;
         end
      endcase
   end

   // Output steering: purely combinational from the current grant, so an
   // asynchronous reset drops every RAM request in the same instant.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      case (state_q)
         DGNT: begin
            ramaddr  = daddr;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramstore = dstore;
            dload    = ramload;
            dwait    = ~ram_done;
         end
         IGNT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            iload   = ramload;
            iwait   = ~ram_done;
         end
         default: begin
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= ARB;
         lock_q   <= 1'b0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         lock_q   <= lock_d;
         starve_q <= starve_d;
      end
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Purpose : Directed, self-checking bench for mem_arbiter. Each cycle the
//           inputs are driven just after the rising edge and the
//           combinational outputs are compared mid-cycle against
//           hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam logic [1:0] RS_FREE   = 2'd0;
   localparam logic [1:0] RS_BUSY   = 2'd1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   int vectorCount = 0;
   int missCount   = 0;

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
   );

   // 10-unit clock period
   always #5 CLK = ~CLK;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive every cache/RAM-side input at once.
   task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] ds,
                                input logic [1:0] rs, input logic [31:0] rl);
      iREN     = ir;
      iaddr    = ia;
      dREN     = dr;
      dWEN     = dw;
      daddr    = da;
      dstore   = ds;
      ramstate = rs;
      ramload  = rl;
   endtask

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge CLK);
      #1;
   endtask

   // Run a series of arbitrations with dWEN and iREN both held and the RAM
   // answering ACCESS immediately; each arbitration takes one ARB cycle and
   // one grant cycle. The expected winner pattern is four dcache grants
   // followed by one icache grant.
   task automatic runStarveSequence(input string tag, input int rounds);
      for (int k = 0; k < rounds; k++) begin
         nextCycle();
         applyStimulus(1'b1, 32'h0000_0088, 1'b0, 1'b1, 32'h0000_0204,
                       32'h5555_5555, RS_ACCESS, 32'h0);
         #1;
         checkOutput({tag, "_arb_req"}, {30'd0, ramWEN, ramREN}, 32'd0);
         nextCycle();
         #1;
         if ((k % 5) == 4) begin
            checkOutput({tag, "_igrant"}, {30'd0, ramWEN, ramREN}, 32'd1);
            checkOutput({tag, "_iaddr"}, ramaddr, 32'h0000_0088);
         end else begin
            checkOutput({tag, "_dgrant"}, {30'd0, ramWEN, ramREN}, 32'd2);
            checkOutput({tag, "_daddr"}, ramaddr, 32'h0000_0204);
         end
      end
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // ---- Reset: outputs must be idle even with requests asserted ----
      nRST = 1'b0;
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFFF,
                    RS_ACCESS, 32'hFFFF_FFFF);
      #12;
      checkOutput("rst_ramREN",   {31'd0, ramREN}, 32'd0);
      checkOutput("rst_ramWEN",   {31'd0, ramWEN}, 32'd0);
      checkOutput("rst_ramaddr",  ramaddr,         32'd0);
      checkOutput("rst_ramstore", ramstore,        32'd0);
      checkOutput("rst_iwait",    {31'd0, iwait},  32'd1);
      checkOutput("rst_dwait",    {31'd0, dwait},  32'd1);
      checkOutput("rst_iload",    iload,           32'd0);
      checkOutput("rst_dload",    dload,           32'd0);

      // ---- Test 1: icache fetch, RAM ACCESS on the 3rd cycle ----
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
      nRST = 1'b1;
      #1;
      checkOutput("t1_arb_ramREN", {31'd0, ramREN}, 32'd0);
      checkOutput("t1_arb_iwait",  {31'd0, iwait},  32'd1);
      for (int c = 1; c <= 2; c++) begin
         nextCycle();
         applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_BUSY, 32'h0);
         #1;
         checkOutput("t1_busy_ramREN",  {31'd0, ramREN}, 32'd1);
         checkOutput("t1_busy_ramaddr", ramaddr,         32'h40);
         checkOutput("t1_busy_iwait",   {31'd0, iwait},  32'd1);
      end
      nextCycle();
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_ACCESS, 32'h1111_2222);
      #1;
      checkOutput("t1_acc_iwait", {31'd0, iwait}, 32'd0);
      checkOutput("t1_acc_iload", iload,          32'h1111_2222);
      checkOutput("t1_acc_dwait", {31'd0, dwait}, 32'd1);

      // ---- Test 2: two-word dcache block with iREN held throughout ----
      nextCycle();
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, RS_FREE, 32'h0);
      #1;
      checkOutput("t2_arb_ramREN", {31'd0, ramREN}, 32'd0);
      checkOutput("t2_arb_dwait",  {31'd0, dwait},  32'd1);
      nextCycle();
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, RS_ACCESS, 32'hAAAA_0000);
      #1;
      checkOutput("t2_w0_ramREN",  {31'd0, ramREN}, 32'd1);
      checkOutput("t2_w0_ramaddr", ramaddr,         32'h100);
      checkOutput("t2_w0_dwait",   {31'd0, dwait},  32'd0);
      checkOutput("t2_w0_dload",   dload,           32'hAAAA_0000);
      checkOutput("t2_w0_iwait",   {31'd0, iwait},  32'd1);
      nextCycle();
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h104, 32'h0, RS_BUSY, 32'h0);
      #1;
      checkOutput("t2_w1_busy_ramREN",  {31'd0, ramREN}, 32'd1);
      checkOutput("t2_w1_busy_ramaddr", ramaddr,         32'h104);
      checkOutput("t2_w1_busy_dwait",   {31'd0, dwait},  32'd1);
      checkOutput("t2_w1_busy_iwait",   {31'd0, iwait},  32'd1);
      nextCycle();
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h104, 32'h0, RS_ACCESS, 32'hBBBB_0000);
      #1;
      checkOutput("t2_w1_dwait", {31'd0, dwait}, 32'd0);
      checkOutput("t2_w1_dload", dload,          32'hBBBB_0000);
      checkOutput("t2_w1_iwait", {31'd0, iwait}, 32'd1);
      nextCycle();
      applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
      #1;
      checkOutput("t2_arb2_ramREN", {31'd0, ramREN}, 32'd0);
      checkOutput("t2_arb2_iwait",  {31'd0, iwait},  32'd1);
      nextCycle();
      applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, RS_ACCESS, 32'hCCCC_0000);
      #1;
      checkOutput("t2_ig_ramREN",  {31'd0, ramREN}, 32'd1);
      checkOutput("t2_ig_ramaddr", ramaddr,         32'h80);
      checkOutput("t2_ig_iwait",   {31'd0, iwait},  32'd0);
      checkOutput("t2_ig_iload",   iload,           32'hCCCC_0000);
      checkOutput("t2_ig_dwait",   {31'd0, dwait},  32'd1);

      // ---- Test 3: starvation limit, 4 dcache grants then 1 icache ----
      runStarveSequence("t3", 10);

      // ---- Test 4: dREN and dWEN together, write wins ----
      nextCycle();
      applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, RS_FREE, 32'h0);
      #1;
      checkOutput("t4_arb_ramWEN", {31'd0, ramWEN}, 32'd0);
      nextCycle();
      applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, RS_BUSY, 32'h0);
      #1;
      checkOutput("t4_ramWEN",   {31'd0, ramWEN}, 32'd1);
      checkOutput("t4_ramREN",   {31'd0, ramREN}, 32'd0);
      checkOutput("t4_ramstore", ramstore,        32'hDEAD_BEEF);
      checkOutput("t4_ramaddr",  ramaddr,         32'h200);
      checkOutput("t4_dwait",    {31'd0, dwait},  32'd1);

      // ---- Test 5: ERROR behaves as BUSY, then ACCESS completes ----
      for (int c = 0; c < 2; c++) begin
         nextCycle();
         applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, RS_ERROR, 32'h0);
         #1;
         checkOutput("t5_err_dwait",    {31'd0, dwait}, 32'd1);
         checkOutput("t5_err_ramWEN",   {31'd0, ramWEN}, 32'd1);
         checkOutput("t5_err_ramaddr",  ramaddr,         32'h200);
         checkOutput("t5_err_ramstore", ramstore,        32'hDEAD_BEEF);
      end
      nextCycle();
      applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, RS_ACCESS, 32'h0);
      #1;
      checkOutput("t5_acc_dwait", {31'd0, dwait}, 32'd0);

      // ---- Test 6: async reset while locked between block words ----
      nextCycle();
      applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 32'h204, 32'h1234_5678, RS_BUSY, 32'h0);
      #1;
      checkOutput("t6_locked_ramWEN",  {31'd0, ramWEN}, 32'd1);
      checkOutput("t6_locked_ramaddr", ramaddr,         32'h204);
      checkOutput("t6_locked_iwait",   {31'd0, iwait},  32'd1);
      #1;
      nRST = 1'b0;
      #1;
      checkOutput("t6_rst_ramWEN",   {31'd0, ramWEN}, 32'd0);
      checkOutput("t6_rst_ramREN",   {31'd0, ramREN}, 32'd0);
      checkOutput("t6_rst_ramaddr",  ramaddr,         32'd0);
      checkOutput("t6_rst_ramstore", ramstore,        32'd0);
      checkOutput("t6_rst_dwait",    {31'd0, dwait},  32'd1);
      checkOutput("t6_rst_iwait",    {31'd0, iwait},  32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
      #1;
      nRST = 1'b1;
      runStarveSequence("t6", 5);

      // ---- Request drop mid-access returns to ARB ----
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, RS_FREE, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, RS_BUSY, 32'h0);
      #1;
      checkOutput("drop_pre_ramREN",  {31'd0, ramREN}, 32'd1);
      checkOutput("drop_pre_ramaddr", ramaddr,         32'h300);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 32'h0, RS_BUSY, 32'h0);
      #1;
      checkOutput("drop_ramREN", {31'd0, ramREN}, 32'd0);
      nextCycle();
      applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0, RS_ACCESS, 32'h77);
      #1;
      checkOutput("drop_arb_iwait", {31'd0, iwait}, 32'd1);
      nextCycle();
      #1;
      checkOutput("drop_ig_ramREN",  {31'd0, ramREN}, 32'd1);
      checkOutput("drop_ig_ramaddr", ramaddr,         32'h84);
      checkOutput("drop_ig_iwait",   {31'd0, iwait},  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule : tb_mem_arbiter
